fifo_burst_reader: RTL and testbench
====================================

# fifo_burst_reader

Read-side controller for the team's 8-bit synchronous FIFO. Watches the FIFO occupancy, drains fixed-length bursts through the FIFO's rd_en/registered-data port, and presents each byte on a valid/ready stream with an end-of-burst marker. It sits between the FIFO output and the downstream packet consumer.

## Interface
- BURST_LEN, 8: bytes per full burst; legal 1..64.
- CNT_W, 7: width of the FIFO occupancy input; must hold 0..64.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset: asynchronous, active-high; clock clk.
- fifo_data  in  8  FIFO registered read data; valid the cycle after rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_count  in  CNT_W  FIFO occupancy.
- fifo_rd_en  out  1  FIFO read strobe.
- flush  in  1  level-sensitive request to drain a partial burst.
- m_data  out  8  output byte.
- m_valid  out  1  m_data valid.
- m_last  out  1  final byte of the current burst; qualified by m_valid.
- m_ready  in  1  downstream accept.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, READ, CAPTURE, SEND, CKSUM (CKSUM present only with macro).
- IDLE: start a burst when fifo_count >= BURST_LEN; the burst length latched into remaining is BURST_LEN. Otherwise start when flush && !fifo_empty; the burst length latched is fifo_count. Transition to READ on the next edge. On start, clear the checksum accumulator.
- READ: fifo_rd_en = (state==READ) && !fifo_empty, decoded combinationally from the registered state. If fifo_empty, remain in READ with rd_en low. Otherwise go to CAPTURE.
- CAPTURE: register fifo_data into m_data. XOR it into the 8-bit accumulator. Decrement remaining. Set m_last when the new remaining is 0 and the macro is off. Go to SEND.
- SEND: hold m_valid=1; m_data and m_last stay stable until m_valid && m_ready at an edge. On handshake:
  - remaining>0: go to READ.
  - remaining==0 and macro on: go to CKSUM.
  - otherwise: go to IDLE.
- The block issues at most one FIFO read outstanding and never asserts rd_en while fifo_empty.
- Width rules:
  - remaining is 7 bits.
  - Lengths compared unsigned.
  - Checksum is XOR with no carry.
- flush is sampled only in IDLE. Deasserting it mid-burst does not shorten the burst.
- Reset, any state: the FSM returns to IDLE immediately. An in-flight read is discarded. The accumulator and remaining clear.
- Reset values:
  - fifo_rd_en=0, m_valid=0, m_last=0, busy=0.
  - m_data=8'h00.

## Timing
- rd_en high in cycle t. Data is visible on fifo_data in cycle t+1 (CAPTURE). m_valid rises in cycle t+2.
- Minimum 3 cycles per byte with m_ready held high.
- A full BURST_LEN=8 burst takes 24 cycles from the first READ to the last handshake, plus 1 cycle for CKSUM.
- The burst-start condition seen in IDLE in cycle c gives the first rd_en in cycle c+1.
- After the last handshake, IDLE is entered. A back-to-back burst issues its next rd_en 2 cycles after that handshake.
- m_ready low stalls SEND indefinitely. No FIFO reads occur during the stall.

## Configuration
- FIFO_RD_CKSUM_EN defined:
  - After the last data byte's handshake, the CKSUM state drives m_data = XOR of all burst bytes, with m_valid=1 and m_last=1, until handshake.
  - The last data byte then has m_last=0.
- Undefined: no CKSUM state. m_last is on the final data byte, and the stream carries data only.

## Test plan
- Reset, then write 8 bytes 0x01..0x08 into the FIFO with m_ready=1 -> 8 handshakes carrying 0x01..0x08, m_last only on 0x08, each rd_en exactly 2 cycles before its m_valid. With the macro: a 9th byte 0x08 (XOR of 0x01..0x08) with m_last, and 0x08 itself with m_last=0.
- 5 bytes 0xA0..0xA4 in the FIFO, flush=0 -> no rd_en and busy=0 for 50 cycles. Assert flush -> 5 bytes out, m_last on 0xA4.
- Burst in progress with m_ready toggling 1-0-0-1 -> m_data is stable while stalled, there are no extra rd_en pulses, and bytes are neither lost nor duplicated.
- 16 bytes in the FIFO -> two 8-byte bursts, and the second burst's first rd_en occurs 2 cycles after the first burst's final handshake.
- rst asserted in CAPTURE of the 3rd byte -> outputs immediately return to reset values. After release, with the remaining 5 bytes plus 3 new bytes written, the next burst starts from the FIFO's current head.
- Force fifo_empty=1 in READ with a short flush count -> rd_en stays low and the FSM holds in READ. Deasserting empty resumes with one rd_en.

Source files
------------

// File: rtl/fifo_burst_reader_if.sv
// Bundle of FIFO read-port, flush request, downstream stream and busy status
// signals for fifo_burst_reader; master is the reader side.
`timescale 1ns/1ps
interface fifo_burst_reader_if #(
  parameter int CNT_W = 7
);
  logic [7:0]       fifo_data;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_rd_en;
  logic             flush;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;
  logic             busy;

  modport master (
    input  fifo_data, fifo_empty, fifo_count, flush, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last, busy
  );

  modport slave (
    output fifo_data, fifo_empty, fifo_count, flush, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last, busy
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains fixed-length (or flushed partial) bursts from an 8-bit FIFO onto a
// valid/ready stream. Define FIFO_RD_CKSUM_EN to append an XOR checksum byte.
`timescale 1ns/1ps
module fifo_burst_reader #(
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 7
) (
  input logic                 clk,
  input logic                 rst,
  fifo_burst_reader_if.master rdr
);

`ifdef FIFO_RD_CKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, CKSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND} state_t;
`endif

  localparam logic [CNT_W-1:0] BurstCnt = CNT_W'(BURST_LEN);
  localparam logic [6:0]       BurstRem = 7'(BURST_LEN);

  state_t     state_q;
  logic [6:0] remaining_q;
  logic [6:0] remaining_d;
  logic [7:0] m_data_q;
  logic       m_valid_q;
  logic       m_last_q;
`ifdef FIFO_RD_CKSUM_EN
  logic [7:0] cksum_q;
`endif

  assign remaining_d    = remaining_q - 7'd1;
  // Only one read can be in flight: the strobe exists for exactly one READ cycle.
  assign rdr.fifo_rd_en = (state_q == READ) && !rdr.fifo_empty;
  assign rdr.m_data     = m_data_q;
  assign rdr.m_valid    = m_valid_q;
  assign rdr.m_last     = m_last_q;
  assign rdr.busy       = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= 7'd0;
      m_data_q    <= 8'h00;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
`ifdef FIFO_RD_CKSUM_EN
      cksum_q     <= 8'h00;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (rdr.fifo_count >= BurstCnt) begin
            remaining_q <= BurstRem;
            state_q     <= READ;
`ifdef FIFO_RD_CKSUM_EN
            cksum_q     <= 8'h00;
`endif
          end else if (rdr.flush && !rdr.fifo_empty) begin
            remaining_q <= 7'(rdr.fifo_count);
            state_q     <= READ;
`ifdef FIFO_RD_CKSUM_EN
            cksum_q     <= 8'h00;
`endif
          end
        end
        READ: begin
          if (!rdr.fifo_empty) begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          m_data_q    <= rdr.fifo_data;
          remaining_q <= remaining_d;
          m_valid_q   <= 1'b1;
`ifdef FIFO_RD_CKSUM_EN
          cksum_q     <= cksum_q ^ rdr.fifo_data;
          m_last_q    <= 1'b0;
`else
          m_last_q    <= (remaining_d == 7'd0);
`endif
          state_q     <= SEND;
        end
        SEND: begin
          if (rdr.m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            if (remaining_q != 7'd0) begin
              state_q <= READ;
            end else begin
`ifdef FIFO_RD_CKSUM_EN
              // Checksum byte follows immediately and closes the burst.
              m_data_q  <= cksum_q;
              m_valid_q <= 1'b1;
              m_last_q  <= 1'b1;
              state_q   <= CKSUM;
`else
              state_q   <= IDLE;
`endif
            end
          end
        end
`ifdef FIFO_RD_CKSUM_EN
        CKSUM: begin
          if (rdr.m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: behavioural FIFO model, stream
// monitor, and hand-computed expected byte streams and cycle spacings.
`timescale 1ns/1ps
module tb_fifo_burst_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_burst_reader_if #(.CNT_W(7)) bus ();

  fifo_burst_reader #(.BURST_LEN(8), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .rdr (bus)
  );

  // Behavioural FIFO: registered read data, one byte per rd_en.
  logic [7:0] fifoMem [0:255];
  logic [7:0] wrPtr = 8'd0;
  logic [7:0] rdPtr = 8'd0;
  logic [7:0] fifoLevel;
  logic       forceEmpty = 1'b0;
  assign fifoLevel      = wrPtr - rdPtr;
  assign bus.fifo_count = fifoLevel[6:0];
  assign bus.fifo_empty = (fifoLevel == 8'd0) || forceEmpty;
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_data <= fifoMem[rdPtr];
      rdPtr         <= rdPtr + 8'd1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] hsData [$];
  logic       hsLast [$];
  int         hsCycle [$];
  int         rdCycle [$];
  int         busySeen = 0;
  int         stallChanges = 0;
  int         stallCycles = 0;
  int         rdWhileValid = 0;
  logic       prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;
  logic       prevLast = 1'b0;

  // Stream monitor sampling mid-cycle; a handshake seen here completes at the next posedge.
  always @(negedge clk) begin
    if (bus.fifo_rd_en) begin
      rdCycle.push_back(cyc);
      if (bus.m_valid) rdWhileValid++;
    end
    if (bus.busy) busySeen++;
    if (prevStall && (bus.m_data != prevData || bus.m_last != prevLast || !bus.m_valid))
      stallChanges++;
    prevStall = bus.m_valid && !bus.m_ready && !rst;
    if (prevStall) stallCycles++;
    prevData = bus.m_data;
    prevLast = bus.m_last;
    if (bus.m_valid && bus.m_ready && !rst) begin
      hsData.push_back(bus.m_data);
      hsLast.push_back(bus.m_last);
      hsCycle.push_back(cyc);
    end
  end

  int vectorCount = 0;
  int missCount = 0;
  logic [7:0] expData [$];
  logic       expLast [$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fl, input logic rdy);
    bus.flush   = fl;
    bus.m_ready = rdy;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushBytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fifoMem[wrPtr] = base + 8'(i);
      wrPtr = wrPtr + 8'd1;
    end
  endtask

  task automatic addBurst(input logic [7:0] base, input int len);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    for (int i = 0; i < len; i++) begin
      b = base + 8'(i);
      x = x ^ b;
      expData.push_back(b);
`ifdef FIFO_RD_CKSUM_EN
      expLast.push_back(1'b0);
`else
      expLast.push_back(i == len - 1);
`endif
    end
`ifdef FIFO_RD_CKSUM_EN
    expData.push_back(x);
    expLast.push_back(1'b1);
`endif
  endtask

  task automatic clearRecords();
    hsData.delete();
    hsLast.delete();
    hsCycle.delete();
    rdCycle.delete();
    expData.delete();
    expLast.delete();
    busySeen = 0;
    stallChanges = 0;
    stallCycles = 0;
    rdWhileValid = 0;
  endtask

  task automatic runUntil(input int expCount, input logic [3:0] pat, input int budget, input string tag);
    int k;
    k = 0;
    while (hsData.size() < expCount && k < budget) begin
      bus.m_ready = pat[k % 4];
      stepCycle();
      k++;
    end
    checkOutput({tag, "_hsCount"}, 32'(hsData.size()), 32'(expCount));
    bus.m_ready = 1'b1;
    repeat (4) stepCycle();
  endtask

  task automatic compareStream(input string tag);
    for (int i = 0; i < expData.size(); i++) begin
      if (i < hsData.size()) begin
        checkOutput($sformatf("%s_data%0d", tag, i), 32'(hsData[i]), 32'(expData[i]));
        checkOutput($sformatf("%s_last%0d", tag, i), 32'(hsLast[i]), 32'(expLast[i]));
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rdEn"},  32'(bus.fifo_rd_en), 32'd0);
    checkOutput({tag, "_valid"}, 32'(bus.m_valid),    32'd0);
    checkOutput({tag, "_last"},  32'(bus.m_last),     32'd0);
    checkOutput({tag, "_busy"},  32'(bus.busy),       32'd0);
    checkOutput({tag, "_data"},  32'(bus.m_data),     32'h00);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int lastIdx;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1);
    repeat (3) stepCycle();
    checkResetOutputs("rst0");
    rst = 1'b0;
    stepCycle();

    // Full burst with a free-flowing consumer.
    clearRecords();
    addBurst(8'h01, 8);
    pushBytes(8'h01, 8);
    runUntil(expData.size(), 4'b1111, 200, "t1");
    compareStream("t1");
    checkOutput("t1_rdCount", 32'(rdCycle.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < rdCycle.size() && i < hsCycle.size())
        checkOutput($sformatf("t1_rdToValid%0d", i), 32'(hsCycle[i] - rdCycle[i]), 32'd2);
    if (hsCycle.size() >= 8 && rdCycle.size() >= 1)
      checkOutput("t1_span", 32'(hsCycle[7] - rdCycle[0]), 32'd23);
`ifdef FIFO_RD_CKSUM_EN
    if (hsCycle.size() >= 9)
      checkOutput("t1_cksumGap", 32'(hsCycle[8] - hsCycle[7]), 32'd1);
`endif

    // Partial burst waits for flush, then drains exactly what was counted.
    clearRecords();
    pushBytes(8'hA0, 5);
    applyStimulus(1'b0, 1'b1);
    repeat (50) stepCycle();
    checkOutput("t2_noRead", 32'(rdCycle.size()), 32'd0);
    checkOutput("t2_noBusy", 32'(busySeen), 32'd0);
    addBurst(8'hA0, 5);
    applyStimulus(1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b1);
    runUntil(expData.size(), 4'b1111, 200, "t2");
    compareStream("t2");
    checkOutput("t2_rdCount", 32'(rdCycle.size()), 32'd5);
    checkOutput("t2_idleAfter", 32'(bus.busy), 32'd0);

    // Consumer back-pressure 1-0-0-1.
    clearRecords();
    addBurst(8'h10, 8);
    pushBytes(8'h10, 8);
    runUntil(expData.size(), 4'b1001, 400, "t3");
    compareStream("t3");
    checkOutput("t3_rdCount", 32'(rdCycle.size()), 32'd8);
    checkOutput("t3_stallStable", 32'(stallChanges), 32'd0);
    checkOutput("t3_noReadInStall", 32'(rdWhileValid), 32'd0);
    checkOutput("t3_stallSeen", 32'(stallCycles > 0), 32'd1);

    // Two back-to-back bursts.
    clearRecords();
    addBurst(8'h20, 8);
    addBurst(8'h28, 8);
    pushBytes(8'h20, 16);
    runUntil(expData.size(), 4'b1111, 300, "t4");
    compareStream("t4");
    checkOutput("t4_rdCount", 32'(rdCycle.size()), 32'd16);
`ifdef FIFO_RD_CKSUM_EN
    lastIdx = 8;
`else
    lastIdx = 7;
`endif
    if (rdCycle.size() > 8 && hsCycle.size() > lastIdx)
      checkOutput("t4_b2bGap", 32'(rdCycle[8] - hsCycle[lastIdx]), 32'd2);

    // Reset while the third byte is in CAPTURE.
    clearRecords();
    pushBytes(8'h30, 8);
    applyStimulus(1'b0, 1'b1);
    k = 0;
    while (rdCycle.size() < 3 && k < 100) begin
      stepCycle();
      k++;
    end
    checkOutput("t5_reachedThird", 32'(rdCycle.size()), 32'd3);
    rst = 1'b1;
    #1;
    checkResetOutputs("t5rst");
    checkOutput("t5_hsBeforeRst", 32'(hsData.size()), 32'd2);
    repeat (2) stepCycle();
    rst = 1'b0;
    clearRecords();
    addBurst(8'h33, 8);
    pushBytes(8'h38, 3);
    runUntil(expData.size(), 4'b1111, 200, "t5");
    compareStream("t5");

    // Empty flag forced while in READ.
    clearRecords();
    pushBytes(8'h40, 3);
    addBurst(8'h40, 3);
    applyStimulus(1'b1, 1'b1);
    k = 0;
    while (!bus.busy && k < 20) begin
      stepCycle();
      k++;
    end
    checkOutput("t6_started", 32'(bus.busy), 32'd1);
    forceEmpty = 1'b1;
    applyStimulus(1'b0, 1'b1);
    #1;
    checkOutput("t6_rdEnLow", 32'(bus.fifo_rd_en), 32'd0);
    repeat (5) stepCycle();
    checkOutput("t6_noRead", 32'(rdCycle.size()), 32'd0);
    checkOutput("t6_holdBusy", 32'(bus.busy), 32'd1);
    forceEmpty = 1'b0;
    runUntil(expData.size(), 4'b1111, 200, "t6");
    compareStream("t6");
    checkOutput("t6_rdCount", 32'(rdCycle.size()), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
